// File: rtl/oumux_seq_pkg.sv
// Shared definitions for the output-mux command sequencer: FSM encoding and command word layout.
package oumux_seq_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // A queued command is {sel, cnt}, with sel in the upper bits.
    function automatic int cmd_width(input int selw, input int cntw);
        return selw + cntw;
    endfunction

endpackage

// File: rtl/oumux_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module oumux_cmd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; validity comes from the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/oumux_seq.sv
// Command sequencer for oumux_ctrl: pops {sel,cnt} commands, issues cnt acknowledged transfers per burst,
// holds sel for the whole burst and abandons a burst whose kernel stays silent for TIMEOUT cycles.
module oumux_seq
    import oumux_seq_pkg::*;
#(
    parameter int SELW    = 4,
    parameter int CNTW    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SELW-1:0] cmd_sel,
    input  logic [CNTW-1:0] cmd_cnt,
    output logic [SELW-1:0] sel,
    output logic            o_req,
    input  logic            o_ack,
    output logic            busy,
    output logic            done,
    output logic            err_to,
    input  logic            err_clr
);

    localparam int CW = cmd_width(SELW, CNTW);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [0:0]      state;
    logic [CNTW-1:0] rem;
    logic [TW-1:0]   tmo;
    logic [CW-1:0]   head;
    logic [SELW-1:0] head_sel;
    logic [CNTW-1:0] head_cnt;
    logic            full;
    logic            empty;
    logic            pop;
    logic            timeout_hit;

    assign pop         = (state == ST_IDLE) & ~empty;
    assign head_sel    = head[CW-1:CNTW];
    assign head_cnt    = head[CNTW-1:0];
    assign timeout_hit = (state == ST_ISSUE) & ~o_ack & (tmo == TW'(TIMEOUT - 1));
    assign cmd_ready   = ~full;
    assign busy        = (state != ST_IDLE) | ~empty;

    oumux_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .pop     (pop),
        .wdata   ({cmd_sel, cmd_cnt}),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            sel    <= '0;
            rem    <= '0;
            tmo    <= '0;
            o_req  <= 1'b0;
            done   <= 1'b0;
            err_to <= 1'b0;
        end else begin
            done <= 1'b0;
            // A fresh timeout wins over a simultaneous clear so the abort is never lost.
            if (timeout_hit)  err_to <= 1'b1;
            else if (err_clr) err_to <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        sel <= head_sel;
                        rem <= head_cnt;
                        tmo <= '0;
                        if (head_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            o_req <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (o_ack) begin
                        rem <= rem - CNTW'(1);
                        tmo <= '0;
                        if (rem == CNTW'(1)) begin
                            state <= ST_IDLE;
                            o_req <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        tmo <= tmo + TW'(1);
                        if (timeout_hit) begin
                            state <= ST_IDLE;
                            o_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    o_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oumux_seq.sv
// Self-checking bench for oumux_seq: queue-based burst model compared every cycle, plus directed scenarios.
module tb_oumux_seq;

    localparam int SELW    = 4;
    localparam int CNTW    = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [SELW-1:0] s;
        logic [CNTW-1:0] c;
    } cmd_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [SELW-1:0] cmd_sel;
    logic [CNTW-1:0] cmd_cnt;
    logic [SELW-1:0] sel;
    logic            o_req;
    logic            o_ack;
    logic            busy;
    logic            done;
    logic            err_to;
    logic            err_clr;

    oumux_seq #(
        .SELW    (SELW),
        .CNTW    (CNTW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_cnt   (cmd_cnt),
        .sel       (sel),
        .o_req     (o_req),
        .o_ack     (o_ack),
        .busy      (busy),
        .done      (done),
        .err_to    (err_to),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending commands, and the burst in flight as "transfers left / silent cycles".
    cmd_t            mq[$];
    bit              m_active;
    int              m_rem;
    int              m_wait;
    logic [SELW-1:0] m_sel;
    bit              m_done;
    bit              m_err;

    // Per-scenario statistics gathered from DUT outputs.
    int              step_no;
    int              tr_req;
    int              tr_done;
    int              first_req;
    int              sel_jumps;
    logic            prev_oreq;
    logic [SELW-1:0] prev_sel;
    logic [SELW-1:0] starts[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_rem    = 0;
        m_wait   = 0;
        m_sel    = '0;
        m_done   = 0;
        m_err    = 0;
    endtask

    task automatic clear_stats();
        tr_req    = 0;
        tr_done   = 0;
        first_req = -1;
        sel_jumps = 0;
        starts.delete();
    endtask

    task automatic model_update();
        bit   was_full;
        bit   timed;
        cmd_t h;
        cmd_t n;
        was_full = (mq.size() == DEPTH);
        timed    = 0;
        m_done   = 0;
        if (!m_active) begin
            if (mq.size() > 0) begin
                h     = mq.pop_front();
                m_sel = h.s;
                if (h.c == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_rem    = int'(h.c);
                    m_wait   = 0;
                end
            end
        end else if (o_ack) begin
            m_rem--;
            m_wait = 0;
            if (m_rem == 0) begin
                m_active = 0;
                m_done   = 1;
            end
        end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_active = 0;
                timed    = 1;
            end
        end
        if (timed)        m_err = 1;
        else if (err_clr) m_err = 0;
        if (cmd_valid && !was_full) begin
            n.s = cmd_sel;
            n.c = cmd_cnt;
            mq.push_back(n);
        end
    endtask

    task automatic compare_all();
        chk("o_req", o_req, m_active);
        chk("sel", sel, m_sel);
        chk("done", done, m_done);
        chk("err_to", err_to, m_err);
        chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
        chk("busy", busy, m_active || (mq.size() != 0));
    endtask

    task automatic step(input logic v, input logic [SELW-1:0] s, input logic [CNTW-1:0] c,
                        input logic a, input logic clr);
        @(negedge clk);
        cmd_valid = v;
        cmd_sel   = s;
        cmd_cnt   = c;
        o_ack     = a;
        err_clr   = clr;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        step_no++;
        if (o_req) begin
            tr_req++;
            if (first_req < 0) first_req = step_no;
            if (!prev_oreq) starts.push_back(sel);
            else if (sel != prev_sel) sel_jumps++;
        end
        if (done) tr_done++;
        prev_oreq = o_req;
        prev_sel  = sel;
    endtask

    task automatic drain(input logic a, input int maxc);
        int n;
        n = 0;
        do begin
            step(1'b0, '0, '0, a, 1'b0);
            n++;
        end while ((busy || o_req) && n < maxc);
        chk("drain_bound", busy, 1'b0);
    endtask

    initial begin
        int push_step;
        int ack_pct;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_cnt   = '0;
        o_ack     = 1'b0;
        err_clr   = 1'b0;
        step_no   = 0;
        prev_oreq = 1'b0;
        prev_sel  = '0;
        model_reset();
        clear_stats();

        #12;
        chk("rst_o_req", o_req, 1'b0);
        chk("rst_sel", sel, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_err_to", err_to, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single burst of 4 with ack held high.
        clear_stats();
        push_step = step_no + 1;
        step(1'b1, 4'd3, 8'd4, 1'b1, 1'b0);
        drain(1'b1, 50);
        chk("t2_req_cycles", tr_req, 4);
        chk("t2_done_pulses", tr_done, 1);
        chk("t2_latency", first_req - push_step + 1, 2);
        chk("t2_sel", sel, 4'd3);

        // Zero-length command.
        clear_stats();
        step(1'b1, 4'd2, 8'd0, 1'b0, 1'b0);
        drain(1'b0, 50);
        chk("t4_done_pulses", tr_done, 1);
        chk("t4_req_cycles", tr_req, 0);
        chk("t4_sel", sel, 4'd2);

        // Ack pattern 1,0,1 on a 2-transfer burst.
        clear_stats();
        step(1'b1, 4'd9, 8'd2, 1'b0, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        drain(1'b0, 20);
        chk("t6_req_cycles", tr_req, 3);
        chk("t6_done_pulses", tr_done, 1);
        chk("t6_sel_jumps", sel_jumps, 0);
        chk("t6_sel", sel, 4'd9);

        // Silence of TIMEOUT-1 cycles before each ack must not abort: the ack restarts the count.
        clear_stats();
        step(1'b1, 4'd6, 8'd2, 1'b0, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            repeat (TIMEOUT - 1) step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
            step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        end
        drain(1'b0, 20);
        chk("t6b_req_cycles", tr_req, 2 * TIMEOUT);
        chk("t6b_err_to", err_to, 1'b0);
        chk("t6b_done_pulses", tr_done, 1);

        // Fill the FIFO behind a stalled burst, overflow once, then drain in order.
        clear_stats();
        step(1'b1, 4'd5, 8'd8, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) step(1'b1, 4'(k), 8'd2, 1'b0, 1'b0);
        chk("t3_ready_full", cmd_ready, 1'b0);
        step(1'b1, 4'd15, 8'd2, 1'b0, 1'b0);
        chk("t3_ready_still_full", cmd_ready, 1'b0);
        drain(1'b1, 100);
        chk("t3_bursts", starts.size(), 5);
        if (starts.size() == 5) begin
            chk("t3_order0", starts[0], 4'd5);
            for (int k = 1; k <= 4; k++) chk("t3_order", starts[k], 4'(k));
        end
        chk("t3_done_pulses", tr_done, 5);

        // Timeout abort, sticky error, next command still runs, then clear.
        clear_stats();
        step(1'b1, 4'd7, 8'd3, 1'b0, 1'b0);
        drain(1'b0, 30);
        chk("t5_req_cycles", tr_req, TIMEOUT);
        chk("t5_err_to", err_to, 1'b1);
        chk("t5_no_done", tr_done, 0);
        step(1'b1, 4'd1, 8'd1, 1'b1, 1'b0);
        drain(1'b1, 20);
        chk("t5_next_req", tr_req, TIMEOUT + 1);
        chk("t5_next_done", tr_done, 1);
        chk("t5_err_sticky", err_to, 1'b1);
        step(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
        chk("t5_err_clr", err_to, 1'b0);

        // Asynchronous reset in the middle of a burst with commands still queued.
        step(1'b1, 4'd6, 8'd9, 1'b1, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 4'd4, 8'd3, 1'b1, 1'b0);
        step(1'b1, 4'd8, 8'd3, 1'b1, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        chk("t1_model_rem", m_rem, 5);
        chk("t1_pre_o_req", o_req, 1'b1);
        #3;
        cmd_valid = 1'b0;
        o_ack     = 1'b0;
        err_clr   = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("t1_o_req", o_req, 1'b0);
        chk("t1_sel", sel, 4'd0);
        chk("t1_err_to", err_to, 1'b0);
        chk("t1_fifo_empty", busy, 1'b0);
        chk("t1_cmd_ready", cmd_ready, 1'b1);
        model_reset();
        prev_oreq = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic with varying acknowledge density.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       ack_pct = 90;
                1:       ack_pct = 50;
                default: ack_pct = 8;
            endcase
            for (int k = 0; k < 250; k++) begin
                step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                     4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 4)),
                     ($urandom_range(0, 99) < ack_pct) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
            end
        end
        drain(1'b1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
